// File: rtl/data_distributor.sv
`timescale 1ns / 1ps
// data_distributor: routes one input word either to a single selected channel (directed mode)
// or to every channel in turn (sweep mode). Channel outputs and strobes are registered.
module data_distributor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CH    = 8,
   parameter int unsigned SEL_W = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   input  logic [SEL_W-1:0]    in_sel,
   input  logic                in_mode,
   output logic [CH*WIDTH-1:0] out_data,
   output logic [CH-1:0]       out_valid,
   output logic                busy,
   output logic                err
);

   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   localparam logic [SEL_W-1:0] LastPtr = SEL_W'(CH - 1);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0]    latch_q, latch_d;
   logic [CH*WIDTH-1:0] data_q, data_d;
   logic [CH-1:0]       valid_q, valid_d;
   logic                err_q, err_d;

   logic                accept;
   logic                sel_ok;
   logic                ptr_last;
   logic                wr_en;
   logic [SEL_W-1:0]    wr_idx;
   logic [WIDTH-1:0]    wr_data;

   assign accept   = in_valid & in_ready;
   // Selects can encode values beyond CH-1 when CH is not a power of two.
   assign sel_ok   = 32'(in_sel) < CH;
   assign ptr_last = (ptr_q == LastPtr);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: a sweep accept enters StSweep, the write of the last channel leaves it
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept && in_mode) state_d = StSweep;
         StSweep: if (ptr_last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Handshake and status outputs decoded purely from state
   always_comb begin
      in_ready = (state_q == StIdle);
      busy     = (state_q == StSweep);
   end

   // Pick the single write for this edge: sweep pointer, directed select, or nothing
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      wr_data = latch_q;
      err_d   = 1'b0;
      ptr_d   = ptr_q;
      latch_d = latch_q;
      if (state_q == StSweep) begin
         wr_en = 1'b1;
         ptr_d = ptr_last ? '0 : ptr_q + SEL_W'(1);
      end else if (accept) begin
         if (in_mode) begin
            latch_d = in_data;
            ptr_d   = '0;
         end else if (sel_ok) begin
            wr_en   = 1'b1;
            wr_idx  = in_sel;
            wr_data = in_data;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Decode the write onto channel data and the one-hot strobe
   always_comb begin
      data_d  = data_q;
      valid_d = '0;
      for (int unsigned k = 0; k < CH; k++) begin
         if (wr_en && (wr_idx == SEL_W'(k))) begin
            data_d[k*WIDTH +: WIDTH] = wr_data;
            valid_d[k]               = 1'b1;
         end
      end
   end

   // Datapath registers, all cleared asynchronously by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         latch_q <= '0;
         data_q  <= '0;
         valid_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         latch_q <= latch_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign err       = err_q;

endmodule
